tmr_fault_monitor: RTL
======================

Name: tmr_fault_monitor

Overview:
Checker at the consuming end of a triplicated datapath. Takes three replica buses, produces a registered bitwise-majority value, and flags the disagreeing replica. It tracks how long each replica has been in error and requests a targeted resynchronisation once a mismatch persists. It counts error events per replica for status readout and raises a sticky alarm when no two replicas agree.

Parameters:
WIDTH, 16, replica and voted data width
CNT_WIDTH, 8, width of each per-replica error-event counter (saturating)
PERSIST, 3, consecutive sampled mismatch cycles before a resync is requested (>=1)
RESYNC_CYCLES, 2, cycles resync_req is held asserted (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
sample_en  in  1  replicas valid this cycle; all state updates are gated by it except the reset, clr_cnt and RESYNC countdown
q_1  in  WIDTH  replica 1 value
q_2  in  WIDTH  replica 2 value
q_3  in  WIDTH  replica 3 value
clr_cnt  in  1  clears err_cnt_* and failed
voted_q  out  WIDTH  registered bitwise majority
fault  out  3  registered per-replica mismatch flags, bit i-1 = replica i
resync_req  out  3  one-hot resync request to the failing replica
failed  out  3  sticky: replica still mismatching on the first sample after its resync window
err_cnt_1  out  CNT_WIDTH  replica 1 mismatch-event count
err_cnt_2  out  CNT_WIDTH  replica 2 mismatch-event count
err_cnt_3  out  CNT_WIDTH  replica 3 mismatch-event count
alarm  out  1  sticky: all three replicas pairwise distinct
state  out  2  FSM state: 0 NORMAL, 1 DEGRADED, 2 RESYNC, 3 ALARM

Behaviour:
- Reset is synchronous, active-high, one clock, clk only. On reset every output is 0, the FSM goes to NORMAL, and all persistence counters are 0.
- maj = (q_1&q_2)|(q_1&q_3)|(q_2&q_3), computed combinationally. mm[i] = (q_i != maj).
- When sample_en=1: voted_q <= maj and fault <= mm. Latency is 1 cycle. When sample_en=0, voted_q and fault hold.
- triple = all pairwise unequal. If exactly two replicas are equal, at most one bit of mm is set.
- Persistence counter pc_i (per replica), updated on sample_en:
  - mm[i]=1: pc_i increments, saturating at PERSIST.
  - mm[i]=0: pc_i clears to 0.
- Error-event counter err_cnt_i increments on a sampled 0->1 transition of mm[i] (previous sampled mm[i]=0, current 1). It saturates at all-ones and never wraps.
- clr_cnt=1 clears err_cnt_* and failed on the next edge. If clr_cnt coincides with an increment, the clear wins. clr_cnt does not affect alarm, the FSM or pc_i.
- FSM (evaluated on sample_en unless noted):
  - NORMAL: triple -> ALARM. Any mm set -> DEGRADED. Otherwise stay.
  - DEGRADED: triple -> ALARM. mm all 0 -> NORMAL. Replica i reaches pc_i == PERSIST on this sample -> RESYNC, latching target i.
  - RESYNC: resync_req[i]=1 for exactly RESYNC_CYCLES clocks, counted regardless of sample_en. pc_i clears on entry. On the first sample_en cycle after the window ends:
    - triple -> ALARM;
    - mm[i] still set -> set failed[i], go to DEGRADED;
    - any other mm set -> DEGRADED;
    - all clear -> NORMAL.
    - Only one resync is outstanding at a time; other replicas' pc keep counting but cannot retrigger until the FSM leaves RESYNC.
  - ALARM: alarm=1. State is absorbing until rst. voted_q and fault keep updating normally. resync_req=0.
- resync_req is 0 in all states other than RESYNC.
- A rst asserted mid-RESYNC or in ALARM returns the block to the reset values on the next edge.

Test Plan:
1. Reset, then sample_en=1 with q_1=q_2=q_3=0x1234 for 5 cycles -> voted_q=0x1234 one cycle after the first sample; fault=000; state NORMAL; all counters 0.
2. q_2=0x1235, others 0x1234, held 3 samples with PERSIST=3 -> fault=010 and state DEGRADED after the 1st sample; err_cnt_2=1; RESYNC on the 3rd sample; resync_req=010 for 2 cycles. q_2 restored to 0x1234 before the window ends -> NORMAL, failed=000.
3. Same as 2, but q_2 stays 0x1235 -> after the window, failed=010 and state DEGRADED. clr_cnt pulse -> failed=000, err_cnt_2=0, state unchanged.
4. q_1=0x0001, q_2=0x0002, q_3=0x0004 -> next cycle voted_q=0x0000, fault=111, alarm=1, state ALARM. Restoring agreement keeps alarm=1 until rst.
5. q_3 toggles mismatch/match 300 times with CNT_WIDTH=8 -> err_cnt_3 saturates at 255. PERSIST is never reached, so resync_req stays 000.
6. sample_en=0 while q_1 mismatches -> voted_q, fault, pc and err_cnt unchanged. Assert rst during RESYNC -> all outputs 0 and state NORMAL after the edge.

Source files
------------

// File: rtl/tmr_fault_monitor.sv
// TMR consumer-side checker: registered bitwise majority vote, per-replica
// mismatch flags, persistence-driven resync requests, error counters and alarm.

module tmr_replica_track #(
  parameter int CNT_WIDTH = 8,
  parameter int PERSIST   = 3,
  parameter int PC_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en_i,
  input  logic                 mm_i,
  input  logic                 mm_prev_i,
  input  logic                 clr_cnt_i,
  input  logic                 pc_clr_i,
  output logic                 hit_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 rise;

  always_comb begin
    pc_d = pc_q;
    if (sample_en_i) begin
      if (!mm_i)                       pc_d = '0;
      else if (pc_q != PC_W'(PERSIST)) pc_d = pc_q + 1'b1;
    end
  end

  // hit is qualified by sample_en so a held mismatch cannot retrigger while idle
  assign hit_o = sample_en_i && (pc_d == PC_W'(PERSIST));
  assign rise  = sample_en_i && mm_i && !mm_prev_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i)               cnt_d = '0;
    else if (rise && !(&cnt_q))  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_clr_i ? '0 : pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt_o = cnt_q;
endmodule

module tmr_fault_monitor #(
  parameter int WIDTH         = 16,
  parameter int CNT_WIDTH     = 8,
  parameter int PERSIST       = 3,
  parameter int RESYNC_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic [WIDTH-1:0]     q_1,
  input  logic [WIDTH-1:0]     q_2,
  input  logic [WIDTH-1:0]     q_3,
  input  logic                 clr_cnt,
  output logic [WIDTH-1:0]     voted_q,
  output logic [2:0]           fault,
  output logic [2:0]           resync_req,
  output logic [2:0]           failed,
  output logic [CNT_WIDTH-1:0] err_cnt_1,
  output logic [CNT_WIDTH-1:0] err_cnt_2,
  output logic [CNT_WIDTH-1:0] err_cnt_3,
  output logic                 alarm,
  output logic [1:0]           state
);
  localparam int PC_W = (PERSIST > 1) ? $clog2(PERSIST + 1) : 1;
  localparam int RC_W = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_RESYNC   = 2'd2,
    ST_ALARM    = 2'd3
  } st_e;

  st_e                           state_q, state_d;
  logic [WIDTH-1:0]              maj, vote_q;
  logic [2:0]                    mm, hit, flt_q;
  logic [2:0]                    tgt_q, tgt_d, fail_set, failed_q, failed_d;
  logic [RC_W-1:0]               rc_q;
  logic                          triple, enter_rs, win_open;
  logic [2:0][CNT_WIDTH-1:0]     cnt;

  assign maj    = (q_1 & q_2) | (q_1 & q_3) | (q_2 & q_3);
  assign mm     = {q_3 != maj, q_2 != maj, q_1 != maj};
  assign triple = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3);
  assign win_open = (rc_q != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      tmr_replica_track #(
        .CNT_WIDTH(CNT_WIDTH),
        .PERSIST  (PERSIST),
        .PC_W     (PC_W)
      ) u_trk (
        .clk        (clk),
        .rst        (rst),
        .sample_en_i(sample_en),
        .mm_i       (mm[gi]),
        .mm_prev_i  (flt_q[gi]),
        .clr_cnt_i  (clr_cnt),
        .pc_clr_i   (enter_rs && tgt_d[gi]),
        .hit_o      (hit[gi]),
        .err_cnt_o  (cnt[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      vote_q <= '0;
      flt_q  <= '0;
    end else if (sample_en) begin
      vote_q <= maj;
      flt_q  <= mm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      tgt_q    <= '0;
      rc_q     <= '0;
      failed_q <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      failed_q <= failed_d;
      if (enter_rs)      rc_q <= RC_W'(RESYNC_CYCLES);
      else if (win_open) rc_q <= rc_q - 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    enter_rs = 1'b0;
    fail_set = '0;
    case (state_q)
      ST_NORMAL: if (sample_en) begin
        if (triple)  state_d = ST_ALARM;
        else if (|mm) state_d = ST_DEGRADED;
      end
      ST_DEGRADED: if (sample_en) begin
        if (triple)      state_d = ST_ALARM;
        else if (!(|mm)) state_d = ST_NORMAL;
        else if (|hit) begin
          state_d  = ST_RESYNC;
          enter_rs = 1'b1;
          // lowest-numbered replica wins a simultaneous persistence hit
          tgt_d    = hit[0] ? 3'b001 : (hit[1] ? 3'b010 : 3'b100);
        end
      end
      ST_RESYNC: if (!win_open && sample_en) begin
        if (triple) state_d = ST_ALARM;
        else if (|(mm & tgt_q)) begin
          fail_set = tgt_q;
          state_d  = ST_DEGRADED;
        end
        else if (|mm) state_d = ST_DEGRADED;
        else          state_d = ST_NORMAL;
      end
      ST_ALARM: state_d = ST_ALARM;
      default:  state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    failed_d = clr_cnt ? 3'b000 : (failed_q | fail_set);
  end

  always_comb begin
    resync_req = (state_q == ST_RESYNC && win_open) ? tgt_q : 3'b000;
    alarm      = (state_q == ST_ALARM);
    state      = state_q;
  end

  assign voted_q   = vote_q;
  assign fault     = flt_q;
  assign failed    = failed_q;
  assign err_cnt_1 = cnt[0];
  assign err_cnt_2 = cnt[1];
  assign err_cnt_3 = cnt[2];
endmodule
